// File: rtl/uart_hex_line_fmt.sv
// Word-to-ASCII hex line formatter feeding a byte-wide UART transmitter.
// Emits optional "0x", uppercase hex digits MSB first, then optional CR LF.
module uart_hex_line_fmt #(
    parameter int WORD_W    = 32,
    parameter bit PREFIX_0X = 1'b0,
    parameter bit EMIT_CRLF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              busy
);

    localparam int NDIG = WORD_W / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((WORD_W % 4) != 0 || WORD_W < 4 || WORD_W > 64) begin : g_bad_w
        $error("uart_hex_line_fmt: WORD_W must be a multiple of 4 in 4..64");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_P0,
        S_P1,
        S_DIG,
        S_CR,
        S_LF
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_word;
    logic [CW-1:0]     r_cnt;
    logic              r_valid;
    logic [7:0]        r_data;

    // The word register shifts left per digit so the next digit is always
    // the top nibble; this avoids a variable-index nibble mux.
    logic [WORD_W-1:0] w_shift;
    logic [3:0]        w_top_in;
    logic [3:0]        w_top_word;
    logic [3:0]        w_top_next;

    assign w_shift    = r_word << 4;
    assign w_top_in   = in_data[WORD_W-1 -: 4];
    assign w_top_word = r_word[WORD_W-1 -: 4];
    assign w_top_next = w_shift[WORD_W-1 -: 4];

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Line sequencer: each transfer advances state and presents the next byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_word  <= in_data;
                        r_cnt   <= LAST;
                        r_valid <= 1'b1;
                        if (PREFIX_0X) begin
                            r_state <= S_P0;
                            r_data  <= 8'h30;
                        end else begin
                            r_state <= S_DIG;
                            r_data  <= hex_ascii(w_top_in);
                        end
                    end
                end
                S_P0: begin
                    if (out_ready) begin
                        r_state <= S_P1;
                        r_data  <= 8'h78;
                    end
                end
                S_P1: begin
                    if (out_ready) begin
                        r_state <= S_DIG;
                        r_data  <= hex_ascii(w_top_word);
                    end
                end
                S_DIG: begin
                    if (out_ready) begin
                        if (r_cnt == '0) begin
                            if (EMIT_CRLF) begin
                                r_state <= S_CR;
                                r_data  <= 8'h0D;
                            end else begin
                                r_state <= S_IDLE;
                                r_valid <= 1'b0;
                                r_data  <= 8'h00;
                            end
                        end else begin
                            r_cnt  <= r_cnt - CW'(1);
                            r_word <= w_shift;
                            r_data <= hex_ascii(w_top_next);
                        end
                    end
                end
                S_CR: begin
                    if (out_ready) begin
                        r_state <= S_LF;
                        r_data  <= 8'h0A;
                    end
                end
                S_LF: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_data  <= 8'h00;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_data  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_line_fmt.sv
// Directed bench for uart_hex_line_fmt: default 32-bit line and an
// 8-bit "0x"-prefixed line without CR LF.
module tb_uart_hex_line_fmt;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid;
    logic [31:0] a_in_data;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [7:0]  a_out_data;
    logic        a_out_ready;
    logic        a_busy;

    logic        b_in_valid;
    logic [7:0]  b_in_data;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic        b_out_ready;
    logic        b_busy;

    int n_cmp;
    int n_err;

    uart_hex_line_fmt u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (a_out_ready),
        .busy      (a_busy)
    );

    uart_hex_line_fmt #(
        .WORD_W    (8),
        .PREFIX_0X (1'b1),
        .EMIT_CRLF (1'b0)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (b_out_ready),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one word to u_a at a negedge and collects 10 bytes.
    // bp: random backpressure; hold: keep in_valid high with changing data.
    task automatic run_a(input logic [31:0] w, input logic [79:0] exp,
                         input bit bp, input bit hold);
        int idx;
        int cyc;
        bit pend;
        logic [7:0] pdata;
        a_in_valid = 1'b1;
        a_in_data  = w;
        chk("in_ready_idle", a_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) a_in_valid = 1'b0;
        chk("in_ready_busy", a_in_ready, 0);
        chk("busy_line", a_busy, 1);
        idx = 0;
        cyc = 0;
        pend = 1'b0;
        pdata = 8'h00;
        while (idx < 10 && cyc < 400) begin
            a_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!bp) chk("valid_nobubble", a_out_valid, 1);
            if (pend) begin
                chk("hold_valid", a_out_valid, 1);
                chk("hold_data", a_out_data, pdata);
            end
            if (a_out_valid && a_out_ready) begin
                chk($sformatf("byte%0d", idx), a_out_data,
                    exp[79-8*idx -: 8]);
                idx++;
            end
            pend  = a_out_valid && !a_out_ready;
            pdata = a_out_data;
            @(negedge clk);
            cyc++;
            if (hold) a_in_data = $urandom;
        end
        if (idx < 10) chk("line_timeout", idx, 10);
        if (!bp) chk("line_cycles", cyc, 10);
        chk("idle_valid", a_out_valid, 0);
        chk("idle_ready", a_in_ready, 1);
        a_out_ready = 1'b1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 8'h00);
        chk("rst_busy", a_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", a_in_ready, 1);

        // Default line, no backpressure.
        run_a(32'hDEADBEEF, 80'h44_45_41_44_42_45_45_46_0D_0A, 1'b0, 1'b0);

        // Same word with random backpressure.
        run_a(32'hDEADBEEF, 80'h44_45_41_44_42_45_45_46_0D_0A, 1'b1, 1'b0);

        // in_valid held with changing data; next word captured right away.
        run_a(32'h89ABCDEF, 80'h38_39_41_42_43_44_45_46_0D_0A, 1'b0, 1'b1);
        run_a(32'hA5C30F96, 80'h41_35_43_33_30_46_39_36_0D_0A, 1'b0, 1'b0);

        // Reset after the third byte.
        a_in_valid = 1'b1;
        a_in_data  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("r_b0", a_out_data, 8'h31);
        @(negedge clk);
        chk("r_b1", a_out_data, 8'h32);
        @(negedge clk);
        chk("r_b2", a_out_data, 8'h33);
        @(negedge clk);
        chk("r_b3", a_out_data, 8'h34);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_data", a_out_data, 8'h00);
        chk("mid_rst_ready", a_in_ready, 1);
        rst_n = 1'b1;
        run_a(32'h00000000, 80'h30_30_30_30_30_30_30_30_0D_0A, 1'b0, 1'b0);

        // 8-bit, prefixed, no CR LF.
        b_in_valid = 1'b1;
        b_in_data  = 8'h0A;
        chk("b_ready", b_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_data  = 8'hFF;
        chk("b_byte0", b_out_data, 8'h30);
        chk("b_valid0", b_out_valid, 1);
        @(negedge clk);
        chk("b_byte1", b_out_data, 8'h78);
        @(negedge clk);
        chk("b_byte2", b_out_data, 8'h30);
        @(negedge clk);
        chk("b_byte3", b_out_data, 8'h41);
        chk("b_valid3", b_out_valid, 1);
        @(negedge clk);
        chk("b_idle_valid", b_out_valid, 0);
        chk("b_idle_ready", b_in_ready, 1);
        chk("b_idle_busy", b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
